// File: rtl/mode_switch_controller_if.sv
// Command channel for mode_switch_controller.
// Ports: cmd_valid, cmd_mode (requester -> controller); cmd_ready, cmd_error (back).
interface mode_switch_controller_if #(
  parameter int MODE_WIDTH = 3
);
  logic                  cmd_valid;
  logic [MODE_WIDTH-1:0] cmd_mode;
  logic                  cmd_ready;
  logic                  cmd_error;

  modport master (
    output cmd_valid,
    output cmd_mode,
    input  cmd_ready,
    input  cmd_error
  );

  modport slave (
    input  cmd_valid,
    input  cmd_mode,
    output cmd_ready,
    output cmd_error
  );
endinterface

// File: rtl/mode_switch_controller.sv
// Mode change sequencer: arbitrates button/command requests and commits after bus quiet.
// Ports: sys_clk, sys_rst, btn_pulse, comm_active, cmd (slave), mode_select, mode_pending, mode_leds.
module mode_switch_controller #(
  parameter int MODE_WIDTH        = 3,
  parameter int QUIET_CYCLES      = 16,
  parameter int BLINK_HALF_PERIOD = 1_048_576
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    btn_pulse,
  input  logic                    comm_active,
  mode_switch_controller_if.slave cmd,
  output logic [MODE_WIDTH-1:0]   mode_select,
  output logic                    mode_pending,
  output logic [MODE_WIDTH-1:0]   mode_leds
);

  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam int BW =
    (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;

  localparam logic [QW-1:0] QUIET_LAST =
    QW'(QUIET_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST =
    BW'(BLINK_HALF_PERIOD - 1);
  localparam logic [MODE_WIDTH-1:0] MODE_RST =
    MODE_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_QUIET,
    COMMIT
  } state_t;

  state_t                state;
  state_t                state_n;
  logic [MODE_WIDTH-1:0] target;
  logic [MODE_WIDTH-1:0] target_n;
  logic [QW-1:0]         quiet_cnt;
  logic [QW-1:0]         quiet_n;
  logic [MODE_WIDTH-1:0] sel_n;
  logic                  error_q;
  logic                  error_n;
  logic [BW-1:0]         blink_cnt;
  logic [BW-1:0]         blink_n;
  logic                  phase;
  logic                  phase_n;
  logic                  pending_n;
  logic [MODE_WIDTH-1:0] leds_n;
  logic                  enter_wait;
  logic                  cmd_accept;
  logic                  cmd_onehot;
  logic [MODE_WIDTH-1:0] sel_rot;
  logic [MODE_WIDTH-1:0] tgt_rot;

  function automatic logic [MODE_WIDTH-1:0] rotl(
    input logic [MODE_WIDTH-1:0] m
  );
    return {m[MODE_WIDTH-2:0], m[MODE_WIDTH-1]};
  endfunction

  function automatic logic onehot(
    input logic [MODE_WIDTH-1:0] m
  );
    return (m != '0) &&
      ((m & (m - MODE_WIDTH'(1))) == '0);
  endfunction

  assign cmd.cmd_ready = (state == IDLE);
  assign cmd.cmd_error = error_q;

  assign cmd_accept = cmd.cmd_valid && cmd.cmd_ready;
  assign cmd_onehot = onehot(cmd.cmd_mode);
  assign sel_rot    = rotl(mode_select);
  assign tgt_rot    = rotl(target);

  always_comb begin
    state_n    = state;
    target_n   = target;
    quiet_n    = quiet_cnt;
    sel_n      = mode_select;
    error_n    = 1'b0;
    enter_wait = 1'b0;
    unique case (state)
      IDLE: begin
        // a command of any kind shadows a same-cycle button press
        if (cmd_accept) begin
          if (!cmd_onehot) begin
            error_n = 1'b1;
          end else if (cmd.cmd_mode != mode_select) begin
            target_n   = cmd.cmd_mode;
            quiet_n    = '0;
            state_n    = WAIT_QUIET;
            enter_wait = 1'b1;
          end
        end else if (btn_pulse) begin
          target_n   = sel_rot;
          quiet_n    = '0;
          state_n    = WAIT_QUIET;
          enter_wait = 1'b1;
        end
      end
      WAIT_QUIET: begin
        if (btn_pulse) begin
          target_n = tgt_rot;
          quiet_n  = '0;
          if (tgt_rot == mode_select) begin
            state_n = IDLE;
          end
        end else if (comm_active) begin
          quiet_n = '0;
        end else begin
          quiet_n = quiet_cnt + QW'(1);
          if (quiet_cnt == QUIET_LAST) begin
            state_n = COMMIT;
          end
        end
      end
      COMMIT: begin
        sel_n   = target;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // LEDs are computed from next-state values so they
  // change on the same edge as the pending flag.
  always_comb begin
    pending_n = (state_n != IDLE);
    blink_n   = '0;
    phase_n   = 1'b0;
    if (pending_n && !enter_wait) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_n = '0;
        phase_n = ~phase;
      end else begin
        blink_n = blink_cnt + BW'(1);
        phase_n = phase;
      end
    end
    if (!pending_n) begin
      leds_n = sel_n;
    end else if (phase_n) begin
      leds_n = '0;
    end else begin
      leds_n = target_n;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= IDLE;
      target       <= MODE_RST;
      quiet_cnt    <= '0;
      mode_select  <= MODE_RST;
      mode_pending <= 1'b0;
      mode_leds    <= MODE_RST;
      error_q      <= 1'b0;
      blink_cnt    <= '0;
      phase        <= 1'b0;
    end else begin
      state        <= state_n;
      target       <= target_n;
      quiet_cnt    <= quiet_n;
      mode_select  <= sel_n;
      mode_pending <= pending_n;
      mode_leds    <= leds_n;
      error_q      <= error_n;
      blink_cnt    <= blink_n;
      phase        <= phase_n;
    end
  end

endmodule

// File: tb/tb_mode_switch_controller.sv
// Self-checking bench for mode_switch_controller.
// Cycle vectors with a scoreboard queue plus hand-driven latency/reset sequences.
module tb_mode_switch_controller;

  localparam int MW  = 3;
  localparam int Q   = 4;
  localparam int BHP = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          btn = 1'b0;
  logic          ca  = 1'b0;
  logic [MW-1:0] sel;
  logic          pend;
  logic [MW-1:0] leds;

  int checks = 0;
  int errors = 0;

  mode_switch_controller_if #(.MODE_WIDTH(MW)) cmd_if ();

  mode_switch_controller #(
    .MODE_WIDTH       (MW),
    .QUIET_CYCLES     (Q),
    .BLINK_HALF_PERIOD(BHP)
  ) dut (
    .sys_clk     (clk),
    .sys_rst     (rst),
    .btn_pulse   (btn),
    .comm_active (ca),
    .cmd         (cmd_if.slave),
    .mode_select (sel),
    .mode_pending(pend),
    .mode_leds   (leds)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] sel;
    logic       pend;
    logic [2:0] leds;
    logic       rdy;
    logic       err;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic       btn;
    logic       cv;
    logic [2:0] cm;
    logic       ca;
    exp_t       e;
  } vec_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic vec_t mk(
    input logic r, input logic b, input logic v,
    input logic [2:0] m, input logic a,
    input logic [2:0] s, input logic p,
    input logic [2:0] l, input logic y,
    input logic er
  );
    vec_t t;
    t.rst    = r;
    t.btn    = b;
    t.cv     = v;
    t.cm     = m;
    t.ca     = a;
    t.e.sel  = s;
    t.e.pend = p;
    t.e.leds = l;
    t.e.rdy  = y;
    t.e.err  = er;
    return t;
  endfunction

  task automatic chk(
    input string nm, input int idx,
    input logic [31:0] act, input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h, expected %0h",
               nm, idx, act, exp);
    end
  endtask

  task automatic cmp_out(input int idx);
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard row %0d: queue empty", idx);
    end else begin
      e = sb.pop_front();
      chk("mode_select",  idx, 32'(sel),  32'(e.sel));
      chk("mode_pending", idx, 32'(pend), 32'(e.pend));
      chk("mode_leds",    idx, 32'(leds), 32'(e.leds));
      chk("cmd_ready",    idx,
          32'(cmd_if.cmd_ready), 32'(e.rdy));
      chk("cmd_error",    idx,
          32'(cmd_if.cmd_error), 32'(e.err));
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    rst              = v.rst;
    btn              = v.btn;
    cmd_if.cmd_valid = v.cv;
    cmd_if.cmd_mode  = v.cm;
    ca               = v.ca;
    sb.push_back(v.e);
    @(posedge clk);
    #1;
    cmp_out(idx);
  endtask

  initial begin
    int   k;
    exp_t e;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_mode  = '0;

    // rst btn cv cm ca | sel pend leds rdy err
    // reset, button 001->010, blink t,t,0,0,t
    tbl.push_back(mk(1,0,0,3'b000,0, 3'b001,0,3'b001,1,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b001,0,3'b001,1,0));
    tbl.push_back(mk(0,1,0,3'b000,0, 3'b001,1,3'b010,0,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b001,1,3'b010,0,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b001,1,3'b000,0,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b001,1,3'b000,0,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b001,1,3'b010,0,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b010,0,3'b010,1,0));
    // cmd 100, comm_active 1,0,0,1,0,0,0,0
    tbl.push_back(mk(0,0,1,3'b100,0, 3'b010,1,3'b100,0,0));
    tbl.push_back(mk(0,0,1,3'b001,1, 3'b010,1,3'b100,0,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b010,1,3'b000,0,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b010,1,3'b000,0,0));
    tbl.push_back(mk(0,0,0,3'b000,1, 3'b010,1,3'b100,0,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b010,1,3'b100,0,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b010,1,3'b000,0,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b010,1,3'b000,0,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b010,1,3'b100,0,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b100,0,3'b100,1,0));
    // wrap: button from 100 commits 001
    tbl.push_back(mk(0,1,0,3'b000,0, 3'b100,1,3'b001,0,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b100,1,3'b001,0,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b100,1,3'b000,0,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b100,1,3'b000,0,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b100,1,3'b001,0,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b001,0,3'b001,1,0));
    // three presses 010->100->001 return to idle
    tbl.push_back(mk(0,1,0,3'b000,0, 3'b001,1,3'b010,0,0));
    tbl.push_back(mk(0,1,0,3'b000,0, 3'b001,1,3'b100,0,0));
    tbl.push_back(mk(0,1,0,3'b000,0, 3'b001,0,3'b001,1,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b001,0,3'b001,1,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b001,0,3'b001,1,0));
    // cmd 010 + button: command wins
    tbl.push_back(mk(0,1,1,3'b010,0, 3'b001,1,3'b010,0,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b001,1,3'b010,0,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b001,1,3'b000,0,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b001,1,3'b000,0,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b001,1,3'b010,0,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b010,0,3'b010,1,0));
    // cmd 001 + button from 010: target 001, not 100
    tbl.push_back(mk(0,1,1,3'b001,0, 3'b010,1,3'b001,0,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b010,1,3'b001,0,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b010,1,3'b000,0,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b010,1,3'b000,0,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b010,1,3'b001,0,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b001,0,3'b001,1,0));
    // non-one-hot commands, one with button dropped
    tbl.push_back(mk(0,0,1,3'b011,0, 3'b001,0,3'b001,1,1));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b001,0,3'b001,1,0));
    tbl.push_back(mk(0,1,1,3'b000,0, 3'b001,0,3'b001,1,1));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b001,0,3'b001,1,0));
    // command equal to current mode, with and without button
    tbl.push_back(mk(0,0,1,3'b001,0, 3'b001,0,3'b001,1,0));
    tbl.push_back(mk(0,1,1,3'b001,0, 3'b001,0,3'b001,1,0));
    // reset while waiting on target 100
    tbl.push_back(mk(0,0,1,3'b100,0, 3'b001,1,3'b100,0,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b001,1,3'b100,0,0));
    tbl.push_back(mk(1,0,0,3'b000,0, 3'b001,0,3'b001,1,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b001,0,3'b001,1,0));
    tbl.push_back(mk(0,0,0,3'b000,0, 3'b001,0,3'b001,1,0));

    foreach (tbl[i]) begin
      run_vec(tbl[i], i);
    end

    // busy bus for 6 cycles then quiet: commit 6+Q+1 edges on
    btn              = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    ca               = 1'b1;
    e.sel  = 3'b010;
    e.pend = 1'b0;
    e.leds = 3'b010;
    e.rdy  = 1'b1;
    e.err  = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    btn = 1'b0;
    chk("pending_rise", 1000, 32'(pend), 32'd1);
    k = 0;
    do begin
      k++;
      ca = (k <= 6);
      @(posedge clk);
      #1;
      if (pend) begin
        chk("ready_low", 1000 + k,
            32'(cmd_if.cmd_ready), 32'd0);
      end
    end while (pend && k < 40);
    chk("commit_latency", 1000, 32'(k), 32'(6 + Q + 1));
    cmp_out(1001);

    // reset from a non-default committed mode
    run_vec(mk(1,0,0,3'b000,0, 3'b001,0,3'b001,1,0), 2000);
    run_vec(mk(0,0,0,3'b000,0, 3'b001,0,3'b001,1,0), 2001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mode_switch_controller.md
# mode_switch_controller

Sequences operating-mode changes for the MITM logic. It accepts mode-change requests from the debounced front-panel button and from a command interface, arbitrating between the two. It defers each change until the intercepted bus has been idle for a quiet period, so the mode never switches mid-transaction. It owns the one-hot `mode_select` register and drives the mode LEDs, which blink while a change is pending.

## Interface
- `MODE_WIDTH`, 3: number of modes; one-hot width; must be ≥ 2.
- `QUIET_CYCLES`, 16: consecutive `comm_active`-low cycles required before commit; must be ≥ 1.
- `BLINK_HALF_PERIOD`, 1_048_576: cycles per LED blink phase while pending; must be ≥ 1.

- `sys_clk`  in  1  system clock; all logic on rising edge.
- `sys_rst`  in  1  synchronous, active-high reset.
- `btn_pulse`  in  1  one-cycle pulse from the debouncer; request for the next mode.
- `cmd_valid`  in  1  command request valid.
- `cmd_mode`  in  MODE_WIDTH  requested mode (one-hot).
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_error`  out  1  one-cycle pulse when an accepted command is not one-hot.
- `comm_active`  in  1  bus transaction in progress (synchronous to `sys_clk`).
- `mode_select`  out  MODE_WIDTH  committed one-hot mode (registered).
- `mode_pending`  out  1  high while a change awaits commit.
- `mode_leds`  out  MODE_WIDTH  LED drive (registered).

## Operation
- State machine: IDLE, WAIT_QUIET, COMMIT.
- The block holds `target` (MODE_WIDTH) and `quiet_cnt` (wide enough to hold QUIET_CYCLES).
- `cmd_ready` is 1 in IDLE and 0 otherwise. It is a combinational decode of state.

**IDLE**
- Accepted command, not one-hot:
  - Pulse `cmd_error` on the next cycle.
  - Stay in IDLE; no other change.
- Accepted command, one-hot, equal to `mode_select`:
  - Consume it; no state change.
- Accepted command, one-hot, different from `mode_select`:
  - Set `target <= cmd_mode` and `quiet_cnt <= 0`.
  - Go to WAIT_QUIET.
- `btn_pulse` with no accepted command:
  - Set `target` to `mode_select` rotated left by 1 (MSB wraps to LSB).
  - Set `quiet_cnt <= 0` and go to WAIT_QUIET.
- Command and `btn_pulse` in the same cycle: the command wins and the button pulse is dropped.

**WAIT_QUIET**
- On each cycle:
  - `comm_active`=1: `quiet_cnt <= 0`.
  - `comm_active`=0: increment `quiet_cnt`.
- When `comm_active`=0 and `quiet_cnt == QUIET_CYCLES-1`, go to COMMIT.
- `btn_pulse` rotates `target` left by 1 and clears `quiet_cnt`.
  - If that rotation makes `target` equal `mode_select`, return to IDLE without a commit.
- Button rotation takes priority over the commit transition in the same cycle.

**COMMIT**
- Set `mode_select <= target` and return to IDLE.
- `btn_pulse` in this cycle is dropped.

**Outputs**
- `mode_pending` = (state != IDLE), registered alongside state.
- LEDs:
  - Not pending: `mode_leds` = `mode_select`.
  - Pending: `mode_leds` alternates between `target` and 0, each for BLINK_HALF_PERIOD cycles.
  - Blink starts in the "show `target`" phase at the cycle pending begins.
  - The blink counter resets on every entry to WAIT_QUIET.

## Timing
- Reset values:
  - `mode_select` = 1 (bit 0), `mode_leds` = 1.
  - `mode_pending` = 0, `cmd_error` = 0.
  - State = IDLE, so `cmd_ready` = 1 in the first cycle after reset.
  - `target` = 1, `quiet_cnt` = 0, blink counter = 0.
- Reset mid-operation discards any pending change; `mode_select` returns to 1.
- Commit latency with `comm_active` held low:
  - Request accepted at edge E0.
  - `mode_pending` rises after E0.
  - `mode_select` updates at edge E0+QUIET_CYCLES+1.
  - `mode_pending` falls at that same edge.
- A `comm_active` high cycle during WAIT_QUIET restarts the full QUIET_CYCLES count.
- `cmd_error` is high exactly one cycle, the cycle after acceptance.
- `mode_leds` lags the internal state by at most 1 cycle.

## Test plan
- Reset, QUIET_CYCLES=4, `comm_active`=0, `btn_pulse` at E0.
  - `mode_pending`=1 after E0.
  - `mode_select` goes 3'b001→3'b010 at E5; `mode_pending`=0 after E5.
- Command `cmd_mode`=3'b100 accepted while `comm_active` toggles 1,0,0,1,0,0,0,0.
  - Commit occurs only after four consecutive low cycles.
  - `cmd_ready`=0 throughout WAIT_QUIET.
- `cmd_valid`+`cmd_mode`=3'b010 and `btn_pulse` in the same cycle, from mode 3'b001.
  - `target`=3'b010; the button is dropped.
  - Final `mode_select`=3'b010.
- Wrap-around, from mode 3'b100 with `comm_active`=0:
  - A button press commits 3'b001.
  - Pressing three times in WAIT_QUIET (3'b010→3'b100→3'b001) returns to IDLE at the third press with no commit.
- `cmd_mode`=3'b011 accepted: `cmd_error` pulses for 1 cycle and `mode_select` is unchanged.
  - `cmd_mode` equal to the current mode: no pending change.
- `sys_rst` asserted during WAIT_QUIET with target 3'b100:
  - Next cycle: `mode_select`=3'b001, `mode_pending`=0, `mode_leds`=3'b001, `cmd_ready`=1.
  - Blink check with BLINK_HALF_PERIOD=2: `mode_leds` shows target, target, 0, 0, target…
